prll_bs_drvr_endpoint: RTL and testbench

PRLL_BS_DRVR_ENDPOINT -- requirements
Module: prll_bs_drvr_endpoint

---
 rtl/prll_bs_drvr_endpoint.sv | 103 ++++++++++
 tb/tb_prll_bs_drvr_endpoint.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/prll_bs_drvr_endpoint.sv
// Bus driver endpoint: host-side TX FIFO toward the bus arbiter, RX FIFO back to the host.
// Ports: clk, reset (async high); host tx_valid/tx_data/tx_ready; bus pndng/pop/D_pop;
//   bus push/D_push; host rx_valid/rx_data/rx_ready; tx_count, rx_count, rx_overflow.
// Optional feature: define DRVR_ADDR_FILTER_EN to drop pushes not addressed to id or broadcast.
module prll_bs_drvr_endpoint #(
  parameter int unsigned bits = 256,
  parameter int unsigned depth = 8,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_valid,
  input  logic [bits-1:0]              tx_data,
  output logic                         tx_ready,
  output logic                         pndng,
  input  logic                         pop,
  output logic [bits-1:0]              D_pop,
  input  logic                         push,
  input  logic [bits-1:0]              D_push,
  output logic                         rx_valid,
  output logic [bits-1:0]              rx_data,
  input  logic                         rx_ready,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic                         rx_overflow
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = $clog2(depth+1);
  localparam logic [cw-1:0] full = cw'(depth);

  logic [bits-1:0] tx_mem [depth];
  logic [bits-1:0] rx_mem [depth];

  logic [aw-1:0] tx_wp;
  logic [aw-1:0] tx_rp;
  logic [aw-1:0] rx_wp;
  logic [aw-1:0] rx_rp;
  logic [cw-1:0] tx_cnt;
  logic [cw-1:0] rx_cnt;
  logic          ovf;

  logic tx_wr;
  logic tx_rd;
  logic addr_ok;
  logic rx_wr;
  logic rx_rd;
  logic rx_drop;

`ifdef DRVR_ADDR_FILTER_EN
  assign addr_ok = (D_push[bits-1 -: 8] == id) ||
                   (D_push[bits-1 -: 8] == broadcast);
`else
  assign addr_ok = 1'b1;
`endif

  // Flags come from the pre-edge counts, so a pop never frees a slot
  // for a write in the same cycle.
  assign tx_ready = (tx_cnt != full);
  assign pndng    = (tx_cnt != '0);
  assign rx_valid = (rx_cnt != '0);

  assign tx_wr   = tx_valid & tx_ready;
  assign tx_rd   = pop & pndng;
  assign rx_wr   = push & addr_ok & (rx_cnt != full);
  assign rx_drop = push & addr_ok & (rx_cnt == full);
  assign rx_rd   = rx_ready & rx_valid;

  assign D_pop    = pndng ? tx_mem[tx_rp] : '0;
  assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;
  assign tx_count = tx_cnt;
  assign rx_count = rx_cnt;
  assign rx_overflow = ovf;

  // Storage is deliberately left out of reset; counts gate visibility.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= tx_data;
    if (rx_wr) rx_mem[rx_wp] <= D_push;
  end

  // Pointers are exactly aw bits wide, so they wrap modulo depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_rd) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + cw'(tx_wr) - cw'(tx_rd);
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_rd) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + cw'(rx_wr) - cw'(rx_rd);
      if (rx_drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prll_bs_drvr_endpoint.sv
// Scoreboard bench for prll_bs_drvr_endpoint: random traffic vs a queue model.
// Honours DRVR_ADDR_FILTER_EN the same way the design does.
module tb_prll_bs_drvr_endpoint;

  localparam int B = 256;
  localparam int D = 8;
  localparam int CW = $clog2(D+1);
  localparam logic [7:0] ID = 8'd0;
  localparam logic [7:0] BC = 8'hFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid = 1'b0;
  logic [B-1:0] tx_data = '0;
  logic tx_ready;
  logic pndng;
  logic pop = 1'b0;
  logic [B-1:0] D_pop;
  logic push = 1'b0;
  logic [B-1:0] D_push = '0;
  logic rx_valid;
  logic [B-1:0] rx_data;
  logic rx_ready = 1'b0;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic rx_overflow;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state: occupancy as seen after the latest edge.
  int mt = 0;
  int mr = 0;
  bit movf = 1'b0;
  logic [B-1:0] exp_tx[$];
  logic [B-1:0] exp_rx[$];

  prll_bs_drvr_endpoint #(
    .bits(B), .depth(D), .id(ID), .broadcast(BC)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [B-1:0] act,
                     input logic [B-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [B-1:0] rnd_pkt();
    logic [B-1:0] p;
    for (int i = 0; i < B/32; i++) p[i*32 +: 32] = $urandom;
    case ($urandom % 3)
      0: p[B-1 -: 8] = ID;
      1: p[B-1 -: 8] = BC;
      default: ;
    endcase
    return p;
  endfunction

  function automatic bit dest_ok(input logic [B-1:0] p);
`ifdef DRVR_ADDR_FILTER_EN
    return (p[B-1 -: 8] == ID) || (p[B-1 -: 8] == BC);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle of stimulus, record expected deliveries, advance model.
  task automatic cycle(input bit tv, input bit pp, input bit ps, input bit rr);
    bit tacc, tpop, racc, rpop, novf;
    int nt, nr;
    tx_valid = tv; tx_data = rnd_pkt(); pop = pp;
    push = ps; D_push = rnd_pkt(); rx_ready = rr;
    tacc = tv && (mt < D);
    tpop = pp && (mt > 0);
    rpop = rr && (mr > 0);
    racc = ps && dest_ok(D_push) && (mr < D);
    novf = movf | (ps && dest_ok(D_push) && (mr == D));
    if (tacc) exp_tx.push_back(tx_data);
    if (racc) exp_rx.push_back(D_push);
    nt = mt + int'(tacc) - int'(tpop);
    nr = mr + int'(racc) - int'(rpop);
    @(posedge clk);
    mt = nt; mr = nr; movf = novf;
    #1;
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on each
  // handshake the DUT accepts.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_count", B'(tx_count), B'(mt));
      chk("rx_count", B'(rx_count), B'(mr));
      chk("tx_ready", B'(tx_ready), B'(mt != D));
      chk("pndng", B'(pndng), B'(mt != 0));
      chk("rx_valid", B'(rx_valid), B'(mr != 0));
      chk("rx_overflow", B'(rx_overflow), B'(movf));
      if (!pndng) chk("d_pop_empty", D_pop, '0);
      if (!rx_valid) chk("rx_data_empty", rx_data, '0);
      if (pop && pndng) begin
        if (exp_tx.size() == 0) chk("tx_sb_empty", B'(1), B'(0));
        else chk("d_pop", D_pop, exp_tx.pop_front());
      end
      if (rx_ready && rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_sb_empty", B'(1), B'(0));
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pndng"}, B'(pndng), '0);
    chk({tag, "_rx_valid"}, B'(rx_valid), '0);
    chk({tag, "_tx_ready"}, B'(tx_ready), B'(1));
    chk({tag, "_tx_count"}, B'(tx_count), '0);
    chk({tag, "_rx_count"}, B'(rx_count), '0);
    chk({tag, "_d_pop"}, D_pop, '0);
    chk({tag, "_rx_data"}, rx_data, '0);
    chk({tag, "_rx_overflow"}, B'(rx_overflow), '0);
  endtask

  task automatic clear_model();
    mt = 0; mr = 0; movf = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;
    chk_en = 1'b1;

    // Fill both FIFOs past capacity; extra pushes must set overflow.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);

    // Mixed random traffic with varying pressure.
    for (int i = 0; i < 600; i++) begin
      int w = (i / 100) % 3;
      cycle(($urandom % 4) < 2 + w, ($urandom % 4) < 3 - w,
            ($urandom % 4) < 1 + w, ($urandom % 4) < 3 - w);
    end

    // Drain, then idle pops on empty FIFOs.
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1);
    chk("tx_sb_left", B'(exp_tx.size()), '0);
    chk("rx_sb_left", B'(exp_rx.size()), '0);

    // Partial burst then asynchronous reset in mid-cycle.
    for (int i = 0; i < 4; i++) cycle(1, 0, i < 3, 0);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("mid");
    clear_model();
    @(posedge clk);
    #1 chk_reset_outputs("hold");
    reset = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 200; i++)
      cycle($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1);
    chk("tx_sb_end", B'(exp_tx.size()), '0);
    chk("rx_sb_end", B'(exp_rx.size()), '0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
